// File: rtl/pwm_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pwm_multi
//  Purpose  : N_CH independent PWM channels sharing one prescaled step
//             counter, edge- or center-aligned, with double-buffered duty
//             codes that switch only at period boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_multi #(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int STEPS = 10,
    parameter int PRESC = 1
) (
    input  logic                SLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                MODE,
    input  logic [N_CH*W-1:0]   Porcentaje,
    input  logic                LOAD,
    output logic [N_CH-1:0]     pwm,
    output logic                PERIOD_END
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    // Compare width wide enough for both cnt and duty plus a spare bit
    localparam int XW = ((CW > W) ? CW : W) + 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(STEPS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [XW-1:0] STEPS_X    = XW'(STEPS);
    localparam logic [W-1:0]  DUTY_MAX   = W'(STEPS);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    dir_t            dir;
    dir_t            dir_nx;
    logic            run;
    logic            mode_act;
    logic            mode_nx;
    logic            tick;
    logic            boundary;

    logic [W-1:0]    pending  [N_CH];
    logic [W-1:0]    duty_act [N_CH];
    logic [W-1:0]    duty_nx  [N_CH];
    logic [W-1:0]    load_val [N_CH];
    logic [N_CH-1:0] pwm_nx;

    // The first edge after EN rises shows cnt=0 with the current duty/mode;
    // afterwards the values that the coming edge will load are used.
    logic            sel_mode;
    logic [XW-1:0]   sel_cnt_x;

    // Next prescaler / step counter / direction and boundary detection
    always_comb begin
        tick     = (presc == PRESC_LAST);
        presc_nx = tick ? '0 : presc + 1'b1;
        cnt_nx   = cnt;
        dir_nx   = dir;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_act) begin
                dir_nx = DIR_UP;
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end else if (dir == DIR_UP) begin
                // Top endpoint is held one extra step while turning down
                if (cnt == CNT_LAST) begin
                    dir_nx = DIR_DOWN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end else begin
                // Bottom endpoint is held one extra step; the turn starts a period
                if (cnt == '0) begin
                    dir_nx   = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
        end
        mode_nx   = boundary ? MODE : mode_act;
        sel_mode  = run ? mode_nx : mode_act;
        sel_cnt_x = run ? XW'(cnt_nx) : '0;
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [XW-1:0] code_x;
            logic [XW-1:0] duty_x;

            // Codes above STEPS saturate to fully-on when captured
            assign code_x      = XW'(Porcentaje[i*W +: W]);
            assign load_val[i] = (code_x > STEPS_X) ? DUTY_MAX : Porcentaje[i*W +: W];

            assign duty_nx[i]  = boundary ? pending[i] : duty_act[i];
            assign duty_x      = run ? XW'(duty_nx[i]) : XW'(duty_act[i]);
            assign pwm_nx[i]   = sel_mode ? (sel_cnt_x >= (STEPS_X - duty_x))
                                          : (sel_cnt_x < duty_x);
        end
    endgenerate

    // Capture all channel codes into the pending buffer on LOAD
    always_ff @(posedge SLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CH; i++) pending[i] <= '0;
        end else if (LOAD) begin
            for (int i = 0; i < N_CH; i++) pending[i] <= load_val[i];
        end
    end

    // Counter, active duty/mode and registered outputs
    always_ff @(posedge SLK or negedge RST_N) begin
        if (!RST_N) begin
            presc      <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            run        <= 1'b0;
            mode_act   <= 1'b0;
            pwm        <= '0;
            PERIOD_END <= 1'b0;
            for (int i = 0; i < N_CH; i++) duty_act[i] <= '0;
        end else if (!EN) begin
            presc      <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            run        <= 1'b0;
            mode_act   <= MODE;
            pwm        <= '0;
            PERIOD_END <= 1'b0;
            for (int i = 0; i < N_CH; i++) duty_act[i] <= pending[i];
        end else if (!run) begin
            run        <= 1'b1;
            pwm        <= pwm_nx;
            PERIOD_END <= 1'b0;
        end else begin
            presc      <= presc_nx;
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            mode_act   <= mode_nx;
            pwm        <= pwm_nx;
            PERIOD_END <= boundary;
            for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_nx[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pwm_multi
//  Purpose  : Self-checking bench for pwm_multi (PRESC=1 and PRESC=3 copies)
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_multi;

    localparam int STEPS = 10;

    logic        SLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        MODE = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] Porcentaje = 16'h0000;
    logic [3:0]  pwm0;
    logic [3:0]  pwm1;
    logic        pe0;
    logic        pe1;

    int checks = 0;
    int errors = 0;

    pwm_multi #(.N_CH(4), .W(4), .STEPS(10), .PRESC(1)) dut0 (
        .SLK(SLK), .RST_N(RST_N), .EN(EN), .MODE(MODE),
        .Porcentaje(Porcentaje), .LOAD(LOAD), .pwm(pwm0), .PERIOD_END(pe0)
    );

    pwm_multi #(.N_CH(4), .W(4), .STEPS(10), .PRESC(3)) dut1 (
        .SLK(SLK), .RST_N(RST_N), .EN(EN), .MODE(MODE),
        .Porcentaje(Porcentaje), .LOAD(LOAD), .pwm(pwm1), .PERIOD_END(pe1)
    );

    always #5 SLK = ~SLK;

    // ------------------------------------------------------------------
    // Reference model: position inside the period as a cycle index t
    // ------------------------------------------------------------------
    int          m_pend [2][4];
    int          m_duty [2][4];
    int          m_t    [2];
    bit          m_run  [2];
    bit          m_mode [2];
    logic [3:0]  m_pwm  [2];
    logic        m_pe   [2];

    function automatic int step_value(int t, int pr, bit center);
        int s;
        s = t / pr;
        if (center && s >= STEPS) return 2*STEPS - 1 - s;
        return s;
    endfunction

    task automatic model_reset(int k);
        for (int j = 0; j < 4; j++) begin
            m_pend[k][j] = 0;
            m_duty[k][j] = 0;
        end
        m_t[k] = 0; m_run[k] = 0; m_mode[k] = 0; m_pwm[k] = 4'h0; m_pe[k] = 1'b0;
    endtask

    task automatic model_step(int k);
        int pr;
        int plen;
        int c;
        int code;
        int newp[4];
        pr = (k == 0) ? 1 : 3;
        for (int j = 0; j < 4; j++) begin
            code    = int'(Porcentaje[j*4 +: 4]);
            newp[j] = LOAD ? ((code > STEPS) ? STEPS : code) : m_pend[k][j];
        end
        m_pe[k] = 1'b0;
        if (!EN) begin
            m_run[k]  = 0;
            m_t[k]    = 0;
            m_mode[k] = MODE;
            for (int j = 0; j < 4; j++) m_duty[k][j] = m_pend[k][j];
            m_pwm[k] = 4'h0;
        end else begin
            if (!m_run[k]) begin
                m_run[k] = 1;
                m_t[k]   = 0;
            end else begin
                plen   = (m_mode[k] ? 2 : 1) * STEPS * pr;
                m_t[k] = m_t[k] + 1;
                if (m_t[k] == plen) begin
                    m_t[k]    = 0;
                    m_pe[k]   = 1'b1;
                    m_mode[k] = MODE;
                    for (int j = 0; j < 4; j++) m_duty[k][j] = m_pend[k][j];
                end
            end
            c = step_value(m_t[k], pr, m_mode[k]);
            for (int j = 0; j < 4; j++)
                m_pwm[k][j] = m_mode[k] ? (c >= STEPS - m_duty[k][j]) : (c < m_duty[k][j]);
        end
        for (int j = 0; j < 4; j++) m_pend[k][j] = newp[j];
    endtask

    always @(posedge SLK or negedge RST_N) begin
        for (int k = 0; k < 2; k++) begin
            if (!RST_N) model_reset(k);
            else        model_step(k);
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of both DUTs against the model
    always @(negedge SLK) begin
        check("model_pwm0", int'(pwm0), int'(m_pwm[0]));
        check("model_pe0",  int'(pe0),  int'(m_pe[0]));
        check("model_pwm1", int'(pwm1), int'(m_pwm[1]));
        check("model_pe1",  int'(pe1),  int'(m_pe[1]));
    end

    // ------------------------------------------------------------------
    // Helpers for the hand-written multi-cycle sequences
    // ------------------------------------------------------------------
    task automatic wait_pe(int k);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge SLK);
            seen = (k == 0) ? pe0 : pe1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_pe%0d: actual none expected PERIOD_END within 200 cycles", k);
        end
    endtask

    // Starts on a cycle showing PERIOD_END; counts pwm[0] high cycles and
    // period length up to the next PERIOD_END
    task automatic count_period(int k, output int hi, output int len);
        hi  = 0;
        len = 0;
        do begin
            hi  += (k == 0) ? int'(pwm0[0]) : int'(pwm1[0]);
            len++;
            @(negedge SLK);
        end while ((((k == 0) ? pe0 : pe1) == 1'b0) && len < 200);
    endtask

    typedef struct {
        logic        en;
        logic        load;
        logic        mode;
        logic [15:0] porc;
        logic [3:0]  pwm;
        logic        pe;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int len;

        // ch0=3, ch1=0, ch2=10, ch3=15 (saturates to 10)
        tbl[0] = '{1'b0, 1'b1, 1'b0, 16'hFA03, 4'b0000, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 16'hFA03, 4'b0000, 1'b0};
        for (int r = 2; r <= 4; r++)  tbl[r] = '{1'b1, 1'b0, 1'b0, 16'hFA03, 4'b1101, 1'b0};
        for (int r = 5; r <= 11; r++) tbl[r] = '{1'b1, 1'b0, 1'b0, 16'hFA03, 4'b1100, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'hFA03, 4'b1101, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 16'hFA03, 4'b1101, 1'b0};

        repeat (2) @(negedge SLK);
        check("reset_pwm0", int'(pwm0), 0);
        check("reset_pe0",  int'(pe0),  0);
        check("reset_pwm1", int'(pwm1), 0);
        RST_N = 1'b1;

        for (int r = 0; r < 14; r++) begin
            EN = tbl[r].en; LOAD = tbl[r].load; MODE = tbl[r].mode; Porcentaje = tbl[r].porc;
            @(negedge SLK);
            check($sformatf("tbl%0d_pwm", r), int'(pwm0), int'(tbl[r].pwm));
            check($sformatf("tbl%0d_pe", r),  int'(pe0),  int'(tbl[r].pe));
        end

        // Mid-period LOAD of 7 only affects the next period
        LOAD = 1'b1; Porcentaje = 16'hFA07;
        @(negedge SLK);
        LOAD = 1'b0;
        wait_pe(0);
        count_period(0, hi, len);
        check("midload_hi7", hi, 7);
        check("edge_len10", len, 10);

        // LOAD of 5 on the boundary edge appears one period later
        repeat (9) @(negedge SLK);
        LOAD = 1'b1; Porcentaje = 16'hFA05;
        @(negedge SLK);
        LOAD = 1'b0;
        check("bndload_pe", int'(pe0), 1);
        count_period(0, hi, len);
        check("bndload_keep7", hi, 7);
        count_period(0, hi, len);
        check("bndload_then5", hi, 5);

        // Center-aligned, duty 4
        MODE = 1'b1; LOAD = 1'b1; Porcentaje = 16'hFA04;
        @(negedge SLK);
        LOAD = 1'b0;
        wait_pe(0);
        count_period(0, hi, len);
        check("center_hi8", hi, 8);
        check("center_len20", len, 20);

        // PRESC=3 copy, edge mode, duty 2
        MODE = 1'b0; LOAD = 1'b1; Porcentaje = 16'hFA02;
        @(negedge SLK);
        LOAD = 1'b0;
        wait_pe(1);
        wait_pe(1);
        count_period(1, hi, len);
        check("presc3_hi6", hi, 6);
        check("presc3_len30", len, 30);

        // Asynchronous reset between edges, then run with no LOAD
        @(negedge SLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_pwm0", int'(pwm0), 0);
        check("async_pe0",  int'(pe0),  0);
        check("async_pwm1", int'(pwm1), 0);
        check("async_pe1",  int'(pe1),  0);
        @(negedge SLK);
        RST_N = 1'b1;
        repeat (25) begin
            @(negedge SLK);
            check("postrst_pwm0", int'(pwm0), 0);
            check("postrst_pwm1", int'(pwm1), 0);
        end
        LOAD = 1'b1; Porcentaje = 16'hFA03;
        @(negedge SLK);
        LOAD = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge SLK);
            EN         = ($urandom_range(0, 199) != 0);
            LOAD       = ($urandom_range(0, 7) == 0);
            Porcentaje = 16'($urandom);
            if ($urandom_range(0, 49) == 0) MODE = ~MODE;
            if ($urandom_range(0, 599) == 0) begin
                #2 RST_N = 1'b0;
                #2 RST_N = 1'b1;
            end
        end
        @(negedge SLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
